data_req_issuer: RTL

- Initiator side of the data-memory SRAM-like interface. Sits between the EX stage and the data SRAM bus.
- Accepts one load/store per cycle from EX, checks alignment, and aligns store data and byte strobes.
- Holds each request stable until addr_ok. Tracks outstanding transactions up to MAX_OUTSTANDING and discards responses that belong to flushed instructions.
- Hands raw read data to MEM, which performs load extension.

---
 rtl/data_req_issuer_pkg.sv | 24 ++
 rtl/data_req_issuer_if.sv | 15 +
 rtl/data_req_issuer_store_align.sv | 23 ++
 rtl/data_req_issuer.sv | 101 ++++++++++
 4 files changed

// File: rtl/data_req_issuer_pkg.sv
// data_req_issuer_pkg: shared size/state encodings, request record and alignment helper
package data_req_issuer_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    localparam logic [0:0] DATA_REQ_IDLE = 1'b0;
    localparam logic [0:0] DATA_REQ_REQ  = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    // Size 3 is illegal and behaves as a word, so bit 1 alone selects word alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == MEM_SIZE_H && lo[0]) || (size[1] && lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_req_issuer_if.sv
// data_req_issuer_if: SRAM-like data bus between the issuer (master) and data memory (slave)
interface data_req_issuer_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_req_issuer_store_align.sv
// data_req_issuer_store_align: byte strobes, replicated store data and misalignment flag
module data_req_issuer_store_align
    import data_req_issuer_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic        i_wr,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_ale
);
    logic [3:0] w_mask;

    // Lane mask by size, shifted into place for sub-word stores; loads drive no strobes.
    always_comb begin
        w_mask  = i_size == MEM_SIZE_B ? 4'b0001 : i_size == MEM_SIZE_H ? 4'b0011 : 4'b1111;
        o_wstrb = !i_wr ? 4'b0000 : i_size[1] ? 4'b1111 : 4'(w_mask << i_addr_lo);
        o_wdata = i_size == MEM_SIZE_B ? {4{i_wdata[7:0]}} :
                  i_size == MEM_SIZE_H ? {2{i_wdata[15:0]}} : i_wdata;
        o_ale   = misaligned(i_size, i_addr_lo);
    end
endmodule

// File: rtl/data_req_issuer.sv
// data_req_issuer: issues EX loads/stores on the data SRAM bus and filters flushed responses
module data_req_issuer
    import data_req_issuer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_req_valid,
    input  logic              i_ex_req_wr,
    input  logic [1:0]        i_ex_req_size,
    input  logic [31:0]       i_ex_req_addr,
    input  logic [31:0]       i_ex_req_wdata,
    output logic              o_ex_req_ready,
    output logic              o_ex_req_ale,
    input  logic              i_flush,
    data_req_issuer_if.master sram,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic [CNT_W-1:0]  o_outstanding,
    output logic              o_idle
);
    logic [0:0]       r_state;
    mem_req_t         r_req;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic             r_pend_discard;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic             w_ale;
    logic             w_ready;
    logic             w_issue;
    logic [CNT_W-1:0] w_out_next;

    data_req_issuer_store_align u_align (
        .i_size    (i_ex_req_size),
        .i_addr_lo (i_ex_req_addr[1:0]),
        .i_wdata   (i_ex_req_wdata),
        .i_wr      (i_ex_req_wr),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_ale     (w_ale)
    );

    // Accept/issue qualifiers and the next outstanding count; a stray data_ok never wraps below zero.
    always_comb begin
        w_ready    = i_ex_req_valid && !w_ale && !i_flush && r_state == DATA_REQ_IDLE &&
                     r_outstanding < CNT_W'(MAX_OUTSTANDING);
        w_issue    = r_state == DATA_REQ_REQ && sram.addr_ok;
        w_out_next = r_outstanding + CNT_W'(w_issue) -
                     CNT_W'(sram.data_ok && (w_issue || r_outstanding != '0));
    end

    // IDLE -> REQ on accept, REQ -> IDLE once the slave takes the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= DATA_REQ_IDLE;
        else if (w_ready) r_state <= DATA_REQ_REQ;
        else if (w_issue) r_state <= DATA_REQ_IDLE;
    end

    // Request fields are captured once at accept and held stable while REQ waits for addr_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_req <= '0;
        else if (w_ready) r_req <= '{wr: i_ex_req_wr, size: i_ex_req_size, addr: i_ex_req_addr,
                                     wstrb: w_wstrb, wdata: w_wdata};
    end

    // Outstanding and discard tracking; a flush condemns everything in flight, and a request
    // still waiting for addr_ok is condemned when the slave finally takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding  <= '0;
            r_discard      <= '0;
            r_pend_discard <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (i_flush) begin
                r_discard      <= w_out_next;
                r_pend_discard <= r_state == DATA_REQ_REQ && !sram.addr_ok;
            end else begin
                r_discard <= r_discard - CNT_W'(sram.data_ok && r_discard != '0) +
                             CNT_W'(w_issue && r_pend_discard);
                if (w_issue) r_pend_discard <= 1'b0;
            end
        end
    end

    assign o_ex_req_ready = w_ready;
    assign o_ex_req_ale   = i_ex_req_valid && w_ale;
    assign sram.req       = r_state == DATA_REQ_REQ;
    assign sram.wr        = r_req.wr;
    assign sram.size      = r_req.size;
    assign sram.addr      = r_req.addr;
    assign sram.wstrb     = r_req.wstrb;
    assign sram.wdata     = r_req.wdata;
    assign o_resp_valid   = sram.data_ok && r_discard == '0 && !i_flush;
    assign o_resp_rdata   = sram.rdata;
    assign o_outstanding  = r_outstanding;
    assign o_idle         = r_state == DATA_REQ_IDLE && r_outstanding == '0 && r_discard == '0;
endmodule
